washer_bank_arbiter: RTL

- Shares one water inlet valve and one drain pump between N_WASHERS washer controllers in a laundromat bank.
- Each washer requests the fill and drain resources independently. Each resource is granted round-robin, one washer at a time.
- Grants are held for a bounded time. A valve-settling gap follows every release.
- A washer whose hold time overruns gets a sticky per-washer fault and is locked out until that fault is cleared.

---
 rtl/washer_pkg.sv | 24 ++
 rtl/rr_resource_arb.sv | 138 +++++++++++++
 rtl/washer_bank_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/washer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : washer_pkg
// Description : Shared types and default timing for the washer bank. The
//               arbiter FSM state encoding lives here, together with the
//               timing defaults that the washer controller timers also use.
// Revision    : 1.0 - initial release
// ============================================================================
package washer_pkg;

    // Per-resource arbiter state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    localparam int DEF_N_WASHERS   = 4;
    localparam int DEF_T_FILL_MAX  = 20;
    localparam int DEF_T_DRAIN_MAX = 16;
    localparam int DEF_T_GAP       = 2;

endpackage
`default_nettype wire

// File: rtl/rr_resource_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_resource_arb
// Description : Round-robin arbiter for one shared resource (valve or pump).
//               Grants are held at most T_MAX cycles, and a T_GAP-cycle dead
//               time follows every release or timeout.
// Revision    : 1.0 - initial release
// Ports       : clk, rstn     - clock, async active-low reset
//               elig          - per-washer eligible request (level)
//               estop         - synchronous stop, forces IDLE
//               gnt           - registered one-hot/zero grant
//               win_next      - combinational winner about to be granted
//               timeout       - pulse: owner held T_MAX cycles, still asking
//               timeout_idx   - owner index qualifying timeout
// ============================================================================
module rr_resource_arb
    import washer_pkg::*;
#(
    parameter int N     = DEF_N_WASHERS,
    parameter int T_MAX = DEF_T_DRAIN_MAX,
    parameter int T_GAP = DEF_T_GAP
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N-1:0]         elig,
    input  logic                 estop,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         win_next,
    output logic                 timeout,
    output logic [$clog2(N)-1:0] timeout_idx
);

    localparam int PW = $clog2(N);
    localparam int HW = $clog2(T_MAX + 1);
    localparam int GW = $clog2(T_GAP + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(T_MAX);
    localparam logic [GW-1:0] GAP_LAST  = GW'(T_GAP);
    localparam logic [PW-1:0] PTR_RST   = PW'(N - 1);

    arb_state_t    state;
    logic [HW-1:0] hold_cnt;
    logic [GW-1:0] gap_cnt;
    logic [PW-1:0] ptr;        // last winner; doubles as owner while in GRANT

    logic          arb_en;
    logic          win_found;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] cand;
    logic          owner_req;

    // First eligible index strictly after the pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = PW'((int'(ptr) + k) % N);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Arbitration happens from IDLE or on the last gap cycle.
    assign arb_en = !estop &&
                    ((state == ST_IDLE) || ((state == ST_GAP) && (gap_cnt == GAP_LAST)));

    always_comb begin
        win_next = '0;
        if (arb_en && win_found) begin
            win_next[win_idx] = 1'b1;
        end
    end

    assign owner_req   = elig[ptr];
    assign timeout     = !estop && (state == ST_GRANT) && owner_req && (hold_cnt == HOLD_LAST);
    assign timeout_idx = ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            ptr      <= PTR_RST;
        end else if (estop) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state    <= ST_GRANT;
                        gnt      <= win_next;
                        ptr      <= win_idx;
                        hold_cnt <= HW'(1);
                    end
                end
                ST_GRANT: begin
                    // hold_cnt counts grant-high cycles including this one
                    if (!owner_req || (hold_cnt == HOLD_LAST)) begin
                        state    <= ST_GAP;
                        gnt      <= '0;
                        hold_cnt <= '0;
                        gap_cnt  <= GW'(1);
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (win_found) begin
                            state    <= ST_GRANT;
                            gnt      <= win_next;
                            ptr      <= win_idx;
                            hold_cnt <= HW'(1);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/washer_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : washer_bank_arbiter
// Description : Shares one inlet valve and one drain pump across a bank of
//               washers. Drain has priority over fill for the same washer,
//               and a hold timeout latches a per-washer fault that locks the
//               washer out of both resources until cleared.
// Revision    : 1.0 - initial release
// Ports       : clk, rstn            - clock, async active-low reset
//               fill_req, drain_req  - per-washer level requests
//               estop                - synchronous emergency stop
//               fault_clr            - per-washer fault clear pulse
//               fill_gnt, drain_gnt  - registered one-hot/zero grants
//               valve_open, pump_on  - OR of the respective grants
//               fault                - sticky hold-timeout flags
// ============================================================================
module washer_bank_arbiter
    import washer_pkg::*;
#(
    parameter int N_WASHERS   = DEF_N_WASHERS,
    parameter int T_FILL_MAX  = DEF_T_FILL_MAX,
    parameter int T_DRAIN_MAX = DEF_T_DRAIN_MAX,
    parameter int T_GAP       = DEF_T_GAP
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_WASHERS-1:0] fill_req,
    input  logic [N_WASHERS-1:0] drain_req,
    input  logic                 estop,
    input  logic [N_WASHERS-1:0] fault_clr,
    output logic [N_WASHERS-1:0] fill_gnt,
    output logic [N_WASHERS-1:0] drain_gnt,
    output logic                 valve_open,
    output logic                 pump_on,
    output logic [N_WASHERS-1:0] fault
);

    localparam int PW = $clog2(N_WASHERS);

    logic [N_WASHERS-1:0] drain_elig;
    logic [N_WASHERS-1:0] fill_elig;
    logic [N_WASHERS-1:0] drain_win_next;
    logic [N_WASHERS-1:0] fill_win_next;
    logic                 drain_to;
    logic                 fill_to;
    logic [PW-1:0]        drain_to_idx;
    logic [PW-1:0]        fill_to_idx;
    logic [N_WASHERS-1:0] fault_set;

    // A washer being handed the pump this cycle, or already pumping, may not
    // win the valve, so no washer ever holds both grants.
    assign drain_elig = drain_req & ~fault;
    assign fill_elig  = fill_req & ~fault & ~drain_gnt & ~drain_win_next;

    rr_resource_arb #(
        .N     (N_WASHERS),
        .T_MAX (T_DRAIN_MAX),
        .T_GAP (T_GAP)
    ) u_drain_arb (
        .clk         (clk),
        .rstn        (rstn),
        .elig        (drain_elig),
        .estop       (estop),
        .gnt         (drain_gnt),
        .win_next    (drain_win_next),
        .timeout     (drain_to),
        .timeout_idx (drain_to_idx)
    );

    rr_resource_arb #(
        .N     (N_WASHERS),
        .T_MAX (T_FILL_MAX),
        .T_GAP (T_GAP)
    ) u_fill_arb (
        .clk         (clk),
        .rstn        (rstn),
        .elig        (fill_elig),
        .estop       (estop),
        .gnt         (fill_gnt),
        .win_next    (fill_win_next),
        .timeout     (fill_to),
        .timeout_idx (fill_to_idx)
    );

    always_comb begin
        fault_set = '0;
        if (drain_to) begin
            fault_set[drain_to_idx] = 1'b1;
        end
        if (fill_to) begin
            fault_set[fill_to_idx] = 1'b1;
        end
    end

    // Set wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fault <= '0;
        end else begin
            fault <= (fault & ~fault_clr) | fault_set;
        end
    end

    assign valve_open = |fill_gnt;
    assign pump_on    = |drain_gnt;

endmodule
`default_nettype wire
